// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM generator.
// Optional complementary outputs with dead time are enabled by PWM_DEADTIME_EN.
package pwm_pkg;

  localparam int unsigned NUM_CH_DEF     = 4;
  localparam int unsigned WIDTH_DEF      = 12;
  localparam int unsigned DT_WIDTH_DEF   = 8;
  localparam int unsigned PERIOD_RST_DEF = 4095;

  // Channel-select width; a single channel still needs a 1-bit select field.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Register-write and pin-side signal bundle for pwm_multi_ch.
// iDeadTime / oPWM_N exist only when PWM_DEADTIME_EN is defined.
interface pwm_multi_ch_if
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
`endif
);

  logic                          iEnable;
  logic                          iPeriodWr;
  logic [WIDTH-1:0]              iPeriod;
  logic                          iDutyWr;
  logic [ch_width(NUM_CH)-1:0]   iCh;
  logic [WIDTH:0]                iDuty;
  logic                          oPeriodEnd;
  logic [NUM_CH-1:0]             oPWM;
`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0]           iDeadTime;
  logic [NUM_CH-1:0]             oPWM_N;
`endif

  modport master (
    output iEnable, iPeriodWr, iPeriod, iDutyWr, iCh, iDuty,
`ifdef PWM_DEADTIME_EN
    output iDeadTime,
    input  oPWM_N,
`endif
    input  oPeriodEnd, oPWM
  );

  modport slave (
    input  iEnable, iPeriodWr, iPeriod, iDutyWr, iCh, iDuty,
`ifdef PWM_DEADTIME_EN
    input  iDeadTime,
    output oPWM_N,
`endif
    output oPeriodEnd, oPWM
  );

endinterface

// File: rtl/pwm_deadtime.sv
// Complementary pair generator for one PWM channel: each output rises only after
// the raw level has been stable for dead_time cycles and falls with its raw edge.
module pwm_deadtime #(
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] dead_time,
  output logic                pwm,
  output logic                pwm_n
);

  logic                raw_q;
  logic [DT_WIDTH-1:0] remain;
  logic [DT_WIDTH-1:0] remain_now;
  logic                settled;

  // A raw edge restarts the dead-time count in the same cycle.
  always_comb begin
    remain_now = (raw != raw_q) ? dead_time : remain;
    settled    = (remain_now == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q  <= 1'b0;
      remain <= '0;
      pwm    <= 1'b0;
      pwm_n  <= 1'b0;
    end else if (!enable) begin
      raw_q  <= 1'b0;
      remain <= dead_time;
      pwm    <= 1'b0;
      pwm_n  <= 1'b0;
    end else begin
      raw_q  <= raw;
      remain <= settled ? '0 : remain_now - 1'b1;
      pwm    <= raw && settled;
      pwm_n  <= !raw && settled;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared period counter, double-buffered period/duty registers
// loaded at terminal count. PWM_DEADTIME_EN adds complementary outputs with dead time.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned PERIOD_RST = PERIOD_RST_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
`endif
) (
  input  logic           iCLK,
  input  logic           iReset,
  pwm_multi_ch_if.slave  bus
);

  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  period_act;
  logic [WIDTH-1:0]  period_sh;
  logic [WIDTH-1:0]  period_nxt;
  logic [WIDTH:0]    duty_act [NUM_CH];
  logic [WIDTH:0]    duty_sh  [NUM_CH];
  logic [WIDTH:0]    duty_nxt [NUM_CH];
  logic              tc;
  logic              load;
  logic [NUM_CH-1:0] raw;
  logic              period_end;

  // Shadow next-values feed the active registers directly, so a write landing on
  // the terminal-count edge takes effect for the very next period.
  always_comb begin
    tc         = bus.iEnable && (cnt == period_act);
    load       = tc || !bus.iEnable;
    period_nxt = bus.iPeriodWr ? bus.iPeriod : period_sh;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      duty_nxt[ch] = (bus.iDutyWr && (32'(bus.iCh) == ch)) ? bus.iDuty : duty_sh[ch];
      raw[ch]      = bus.iEnable && ({1'b0, cnt} < duty_act[ch]);
    end
  end

  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) begin
      cnt        <= '0;
      period_act <= WIDTH'(PERIOD_RST);
      period_sh  <= WIDTH'(PERIOD_RST);
      period_end <= 1'b0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        duty_act[ch] <= '0;
        duty_sh[ch]  <= '0;
      end
    end else begin
      period_sh  <= period_nxt;
      period_end <= tc;
      cnt        <= load ? '0 : cnt + 1'b1;
      if (load) period_act <= period_nxt;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        duty_sh[ch] <= duty_nxt[ch];
        if (load) duty_act[ch] <= duty_nxt[ch];
      end
    end
  end

  assign bus.oPeriodEnd = period_end;

`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0] dt_act;
  logic [NUM_CH-1:0]   pwm_p;
  logic [NUM_CH-1:0]   pwm_n;

  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset)    dt_act <= '0;
    else if (load) dt_act <= bus.iDeadTime;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dt
    pwm_deadtime #(.DT_WIDTH(DT_WIDTH)) u_dt (
      .clk       (iCLK),
      .rst       (iReset),
      .enable    (bus.iEnable),
      .raw       (raw[g]),
      .dead_time (dt_act),
      .pwm       (pwm_p[g]),
      .pwm_n     (pwm_n[g])
    );
  end

  assign bus.oPWM   = pwm_p;
  assign bus.oPWM_N = pwm_n;
`else
  logic [NUM_CH-1:0] pwm_q;

  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) pwm_q <= '0;
    else        pwm_q <= raw;
  end

  assign bus.oPWM = pwm_q;
`endif

endmodule
